// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, instr} pairs and
// presents the oldest entry with its pc+8 link value.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc_plus8,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PONE = PTR_W'(1);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_pc       = mem[rd_ptr][63:32];
    assign out_instr    = mem[rd_ptr][31:0];
    assign out_pc_plus8 = out_pc + 32'd8;

    // Storage is deliberately left out of reset; only pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_pc, in_instr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CONE;
                2'b01:   count <= count - CONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage (PC register + instruction memory) and the decode stage. Each cycle it accepts one fetched {PC, instruction} pair and buffers up to DEPTH entries. It presents the oldest entry to decode, together with that entry's PC+8 link value. Its `in_ready` drives the fetch stage's PC enable, and its `flush` input discards wrong-path instructions on a redirect.

## Interface
- `DEPTH`, default 4: number of entries; must be a power of 2, minimum 2.
- `PTR_W`, default 2: pointer width, equal to log2(DEPTH).
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-low. Asserting it (0) clears all state immediately; release is sampled on `clk`.
- `in_valid` input, 1 bit: fetch presents a valid pair this cycle.
- `in_pc` input, 32 bits: PC of the fetched instruction.
- `in_instr` input, 32 bits: the fetched instruction word.
- `in_ready` output, 1 bit: the queue can accept a pair this cycle; used as the fetch PC enable.
- `flush` input, 1 bit: discard all buffered entries and the current input.
- `out_valid` output, 1 bit: the head entry is valid.
- `out_pc` output, 32 bits: PC of the head entry.
- `out_instr` output, 32 bits: instruction of the head entry.
- `out_pc_plus8` output, 32 bits: head entry PC + 8, the link value.
- `out_ready` input, 1 bit: decode consumes the head entry this cycle.
- `count` output, PTR_W+1 bits: current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × 64-bit entries, each {pc, instr}. Read pointer `rd_ptr`, write pointer `wr_ptr`, occupancy `count`.
- Full when `count` == DEPTH; empty when `count` == 0.
- `in_ready` = !full. It is a function of registered state only; there is no combinational path from `out_ready`.
- push = `in_valid` & `in_ready` & !`flush`.
- pop = `out_valid` & `out_ready` & !`flush`.
- On push: write the entry at `wr_ptr`; `wr_ptr` advances by 1 and wraps modulo DEPTH.
- On pop: `rd_ptr` advances by 1 and wraps modulo DEPTH.
- `count` update: +1 on push only, −1 on pop only, unchanged when push and pop occur together.
- Push and pop in the same cycle are legal at any occupancy below DEPTH.
- Full case: no push is possible because `in_ready` = 0, so a pop alone frees a slot and `in_ready` rises the next cycle.
- Flush: `rd_ptr`, `wr_ptr` and `count` all go to 0. The concurrent input pair is dropped and no pop is reported. Flush has priority over push and pop.
- Outputs: `out_valid` = !empty. `out_pc` and `out_instr` are a combinational read of entry `rd_ptr`. `out_pc_plus8` = `out_pc` + 32'd8, mod 2^32 with no carry out.
- When empty, `out_pc`, `out_instr` and `out_pc_plus8` hold stale storage contents and are don't-care. Decode must qualify them with `out_valid`.
- Storage contents are not reset; only pointers and `count` are.

## Timing
- Reset (`rst` = 0), asynchronously: `count` = 0, `out_valid` = 0, `in_ready` = 1, both pointers = 0.
- Latency: a pair pushed at edge N appears on the outputs after edge N, i.e. one cycle after presentation. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle, sustained.
- `in_ready` falls in the cycle after the DEPTH-th push with no pop. It rises in the cycle after the first pop from full.
- Flush at edge N: the queue is empty after N. A push at edge N+1 is accepted normally.
- Reset asserted mid-operation: the queue is empty immediately, without waiting for a clock edge. The first push is accepted on the first rising edge after release.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset then idle: drive `rst` = 0 asynchronously mid-cycle -> `count` = 0, `out_valid` = 0, `in_ready` = 1 before the next edge.
- Fill to full, DEPTH = 4, `out_ready` = 0: push pcs 0x3000, 0x3004, 0x3008, 0x300C -> `count` = 4, `in_ready` = 0. A fifth `in_valid` is ignored, and `out_pc` stays 0x3000 with `out_pc_plus8` = 0x3008.
- Streaming: `in_valid` = `out_ready` = 1 for 10 cycles with pcs 0x3000 upward in steps of 4 -> `count` holds at 1, `out_pc` equals the input pc of the previous cycle, and the output order matches the input order across pointer wrap.
- Pop at full: with `count` = 4, pulse `out_ready` for one cycle -> `count` = 3, `in_ready` = 1 in the next cycle, and `out_pc` advances to 0x3004.
- Flush with simultaneous push and pop: `count` = 2, `flush` = `in_valid` = `out_ready` = 1 -> `count` = 0, `out_valid` = 0. The next push of 0x4000 appears at `out_pc` one cycle later.
- Wrap-around address: push pc 0xFFFFFFFC -> `out_pc_plus8` = 0x00000004.
